ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the registered ID/EX outputs (E-suffixed signals) and applies operand forwarding.
- Performs the ALU operation, selects the destination register and computes the branch target.
- Captures all results in the EX/MEM pipeline register (M-suffixed outputs), with stall and flush control.
- Sits between the ID/EX register and the data-memory stage; the hazard unit drives its forward, stall and flush inputs.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-index width.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RegWriteE, MemToRegE, MemWriteE, BranchE, ALUSrcE, RegDstE  in  1 each  control from ID/EX.
- ALUControlE  in  3  ALU op select.
- RD1E, RD2E  in  DATA_W  register-file operands.
- RTE, RDE  in  REG_W  candidate destination indices.
- SignImmE  in  DATA_W  sign-extended immediate.
- PCPlus4E  in  DATA_W  PC+4 of the instruction.
- ForwardAE, ForwardBE  in  2  operand forward select.
- ResultW  in  DATA_W  writeback result for forwarding.
- StallM  in  1  hold the EX/MEM register.
- FlushM  in  1  insert a bubble.
- RegWriteM, MemToRegM, MemWriteM, BranchM  out  1 each  registered control.
- ZeroM  out  1  registered ALU zero flag.
- ValidM  out  1  1 = register holds a real instruction.
- ALUOutM  out  DATA_W  registered ALU result.
- WriteDataM  out  DATA_W  registered store data.
- WriteRegM  out  REG_W  registered destination index.
- PCBranchM  out  DATA_W  registered branch target.

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous, active-high; while asserted, every M output is 0, including ValidM.
- Forwarding, operand A (SrcA) by ForwardAE:
  - 00 selects RD1E; 01 selects ResultW; 10 selects ALUOutM (this block's own registered output); 11 is reserved and behaves as 00.
- Forwarding, operand B (fwdB) by ForwardBE: same encoding, applied to RD2E.
- SrcB = ALUSrcE ? SignImmE : fwdB. WriteData = fwdB, taken before the ALUSrc mux.
- ALUControlE encoding:
  - 000 A&B; 001 A|B; 010 A+B; 011 reserved, result 0; 100 A&~B; 101 A|~B; 110 A-B; 111 SLT.
  - SLT is a signed comparison returning 32'h1 or 32'h0.
  - Add and subtract wrap modulo 2^DATA_W; no overflow flag or trap.
- Zero = (ALU result == 0), evaluated on the ALU result for every op.
- WriteReg = RegDstE ? RDE : RTE.
- PCBranch = PCPlus4E + (SignImmE << 2), wrapping modulo 2^DATA_W; bits shifted out are discarded.
- EX/MEM register update on rising CLK, in priority order:
  - RST: all outputs 0.
  - FlushM=1: all outputs 0, so ValidM=0 and all writes and branches are suppressed.
  - StallM=1: every output holds its value.
  - Otherwise: load the computed values and set ValidM=1.
- Simultaneous FlushM and StallM: flush wins.
- Latency: exactly 1 cycle from E inputs to M outputs; throughput 1 instruction per cycle when StallM=0.
- The ALUOutM feedback path uses the pre-update register value, so there is no combinational loop.
- Reset mid-stall or mid-flush clears immediately (asynchronously); the first post-reset edge with no flush or stall loads normally.
- No X propagation on reserved encodings; both reserved cases are defined above.

Decomposition:
- Package mips_pkg holds:
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT.
  - Forward-select constants: FWD_RF, FWD_WB, FWD_MEM.
  - DATA_W and REG_W defaults.
- One sub-module, alu_unit: combinational, inputs A, B and ALUControl; outputs result and zero.
- Forward muxes, PC-branch adder and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset behaviour: assert RST mid-cycle with nonzero E inputs -> all M outputs 0 immediately. Release RST, drive RD1E=5, RD2E=3, ALUControlE=010, RegWriteE=1 -> next edge ALUOutM=8, ValidM=1, ZeroM=0.
- Subtract wrap and SLT: RD1E=0, RD2E=1, op 110 -> ALUOutM=32'hFFFFFFFF. Then RD1E=32'hFFFFFFFF (-1), RD2E=1, op 111 -> ALUOutM=1. Then RD1E=RD2E=7, op 110 -> ZeroM=1.
- Forwarding: ALUOutM=0x10, ResultW=0x20, RD1E=RD2E=0, ForwardAE=10, ForwardBE=01, op 010 -> ALUOutM=0x30, WriteDataM=0x20. Then ForwardAE=11 -> RD1E is used.
- Immediate and destination select: ALUSrcE=1, SignImmE=32'hFFFFFFFC, RD1E=10, RegDstE=0, RTE=9, RDE=4, MemWriteE=1 -> ALUOutM=6, WriteRegM=9, WriteDataM=RD2E (unaffected by ALUSrc).
- Branch target: PCPlus4E=0x100, SignImmE=32'hFFFFFFFF, BranchE=1 -> PCBranchM=0xFC, BranchM=1.
- Stall/flush: load an add (ALUOutM=8); next cycle StallM=1 with new inputs -> outputs unchanged. Then StallM=1 and FlushM=1 -> all outputs 0, ValidM=0. Then both low -> normal load resumes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU op codes, forward selects, widths.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;

  // ALU operation select; 3'b011 is reserved and yields zero.
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  // Operand forward select; 2'b11 is reserved and behaves as FWD_RF.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage: logic ops, wrapping add/sub, signed SLT.
module alu_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Select the ALU result; reserved encoding produces zero.
  always_comb begin
    result = '0;
    case (ALUControl)
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_ADD:  result = A + B;
      ALU_ANDN: result = A & ~B;
      ALU_ORN:  result = A | ~B;
      ALU_SUB:  result = A - B;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, branch target, EX/MEM register.
module ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWriteE,
  input  logic              MemToRegE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic              RegDstE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [REG_W-1:0]  RTE,
  input  logic [REG_W-1:0]  RDE,
  input  logic [DATA_W-1:0] SignImmE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              StallM,
  input  logic              FlushM,
  output logic              RegWriteM,
  output logic              MemToRegM,
  output logic              MemWriteM,
  output logic              BranchM,
  output logic              ZeroM,
  output logic              ValidM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_W-1:0]  WriteRegM,
  output logic [DATA_W-1:0] PCBranchM
);

  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] srcB;
  logic [DATA_W-1:0] aluResult;
  logic              aluZero;
  logic [REG_W-1:0]  writeReg;
  logic [DATA_W-1:0] pcBranch;

  // Operand A forwarding; the MEM path reads the current (pre-update) ALUOutM.
  always_comb begin
    srcA = RD1E;
    case (ForwardAE)
      FWD_WB:  srcA = ResultW;
      FWD_MEM: srcA = ALUOutM;
      default: srcA = RD1E;
    endcase
  end

  // Operand B forwarding; store data is taken here, ahead of the immediate mux.
  always_comb begin
    fwdB = RD2E;
    case (ForwardBE)
      FWD_WB:  fwdB = ResultW;
      FWD_MEM: fwdB = ALUOutM;
      default: fwdB = RD2E;
    endcase
  end

  assign srcB     = ALUSrcE ? SignImmE : fwdB;
  assign writeReg = RegDstE ? RDE : RTE;
  assign pcBranch = PCPlus4E + (SignImmE << 2);

  alu_unit #(
    .DATA_W(DATA_W)
  ) u_alu (
    .A         (srcA),
    .B         (srcB),
    .ALUControl(ALUControlE),
    .result    (aluResult),
    .zero      (aluZero)
  );

  // EX/MEM register: reset, then flush (bubble), then stall (hold), else load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      BranchM    <= 1'b0;
      ZeroM      <= 1'b0;
      ValidM     <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      PCBranchM  <= '0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      BranchM    <= 1'b0;
      ZeroM      <= 1'b0;
      ValidM     <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      PCBranchM  <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemToRegM  <= MemToRegE;
      MemWriteM  <= MemWriteE;
      BranchM    <= BranchE;
      ZeroM      <= aluZero;
      ValidM     <= 1'b1;
      ALUOutM    <= aluResult;
      WriteDataM <= fwdB;
      WriteRegM  <= writeReg;
      PCBranchM  <= pcBranch;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus randomized stimulus against a behavioural model.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteE, MemToRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E, ResultW;
  logic [4:0]  RTE, RDE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallM, FlushM;
  logic        RegWriteM, MemToRegM, MemWriteM, BranchM, ZeroM, ValidM;
  logic [31:0] ALUOutM, WriteDataM, PCBranchM;
  logic [4:0]  WriteRegM;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic        regWrite, memToReg, memWrite, branch, zero, valid;
    logic [31:0] aluOut, writeData, pcBranch;
    logic [4:0]  writeReg;
  } model_t;

  model_t m;

  ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .RTE(RTE), .RDE(RDE),
    .SignImmE(SignImmE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .BranchM(BranchM), .ZeroM(ZeroM), .ValidM(ValidM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .PCBranchM(PCBranchM)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t zero_model();
    model_t z;
    z.regWrite = 0; z.memToReg = 0; z.memWrite = 0; z.branch = 0;
    z.zero = 0; z.valid = 0; z.aluOut = 0; z.writeData = 0;
    z.pcBranch = 0; z.writeReg = 0;
    return z;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] mem);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  // Next EX/MEM contents from the current inputs and the current modelled register.
  function automatic model_t model_next(input model_t cur);
    model_t n;
    logic [31:0] a, b, bsrc, r;
    longint sa, sb;
    if (FlushM) return zero_model();
    if (StallM) return cur;
    a = pick(ForwardAE, RD1E, cur.aluOut);
    b = pick(ForwardBE, RD2E, cur.aluOut);
    bsrc = ALUSrcE ? SignImmE : b;
    sa = longint'($signed(a));
    sb = longint'($signed(bsrc));
    case (ALUControlE)
      3'd0: r = a & bsrc;
      3'd1: r = a | bsrc;
      3'd2: r = 32'(longint'(a) + longint'(bsrc));
      3'd4: r = a & ~bsrc;
      3'd5: r = a | ~bsrc;
      3'd6: r = 32'(longint'(a) - longint'(bsrc));
      3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    n.regWrite = RegWriteE; n.memToReg = MemToRegE; n.memWrite = MemWriteE;
    n.branch = BranchE; n.valid = 1'b1;
    n.aluOut = r; n.zero = (r == 0);
    n.writeData = b;
    n.writeReg = RegDstE ? RDE : RTE;
    n.pcBranch = 32'(longint'(PCPlus4E) + 4 * longint'(SignImmE));
    return n;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".RegWriteM"},  32'(RegWriteM),  32'(m.regWrite));
    check({tag, ".MemToRegM"},  32'(MemToRegM),  32'(m.memToReg));
    check({tag, ".MemWriteM"},  32'(MemWriteM),  32'(m.memWrite));
    check({tag, ".BranchM"},    32'(BranchM),    32'(m.branch));
    check({tag, ".ZeroM"},      32'(ZeroM),      32'(m.zero));
    check({tag, ".ValidM"},     32'(ValidM),     32'(m.valid));
    check({tag, ".ALUOutM"},    ALUOutM,         m.aluOut);
    check({tag, ".WriteDataM"}, WriteDataM,      m.writeData);
    check({tag, ".WriteRegM"},  32'(WriteRegM),  32'(m.writeReg));
    check({tag, ".PCBranchM"},  PCBranchM,       m.pcBranch);
  endtask

  // Apply current inputs across one rising edge and compare everything afterwards.
  task automatic step(input string tag);
    model_t n;
    n = model_next(m);
    @(posedge CLK);
    #1;
    m = n;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; MemToRegE = 0; MemWriteE = 0; BranchE = 0; ALUSrcE = 0; RegDstE = 0;
    ALUControlE = 3'd0; RD1E = 0; RD2E = 0; RTE = 0; RDE = 0; SignImmE = 0;
    PCPlus4E = 0; ResultW = 0; ForwardAE = 0; ForwardBE = 0; StallM = 0; FlushM = 0;
  endtask

  task automatic randomize_inputs();
    RegWriteE = 1'($urandom); MemToRegE = 1'($urandom); MemWriteE = 1'($urandom);
    BranchE = 1'($urandom); ALUSrcE = 1'($urandom); RegDstE = 1'($urandom);
    ALUControlE = 3'($urandom);
    RD1E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
    RTE = 5'($urandom); RDE = 5'($urandom);
    SignImmE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    StallM = ($urandom_range(0, 5) == 0);
    FlushM = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    clear_inputs();
    m = zero_model();
    RST = 1'b1;
    #12;
    check_all("reset");

    // Load something nonzero, then assert reset mid-cycle: outputs clear at once.
    RST = 1'b0;
    @(negedge CLK);
    RD1E = 32'h1234; RD2E = 32'h1; ALUControlE = 3'd2; RegWriteE = 1; BranchE = 1;
    PCPlus4E = 32'h40;
    step("preload");
    #2 RST = 1'b1;
    #1;
    m = zero_model();
    check_all("async_rst");
    @(negedge CLK);
    RST = 1'b0;

    // Add after reset release.
    clear_inputs();
    RD1E = 5; RD2E = 3; ALUControlE = 3'd2; RegWriteE = 1;
    step("add");
    check("add.const", ALUOutM, 32'd8);
    check("add.valid", 32'(ValidM), 32'd1);

    // Subtract wraps, signed SLT, zero flag.
    clear_inputs();
    RD1E = 0; RD2E = 1; ALUControlE = 3'd6;
    step("subwrap");
    check("subwrap.const", ALUOutM, 32'hFFFF_FFFF);
    RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 3'd7;
    step("slt");
    check("slt.const", ALUOutM, 32'd1);
    RD1E = 7; RD2E = 7; ALUControlE = 3'd6;
    step("subzero");
    check("subzero.const", 32'(ZeroM), 32'd1);

    // Forwarding from MEM and WB, then the reserved select falls back to RD1E.
    RD1E = 32'h10; RD2E = 0; ALUControlE = 3'd2;
    step("fwd_setup");
    RD1E = 0; RD2E = 0; ResultW = 32'h20; ForwardAE = 2'd2; ForwardBE = 2'd1;
    step("fwd");
    check("fwd.const", ALUOutM, 32'h30);
    check("fwd.wdata", WriteDataM, 32'h20);
    RD1E = 5; ForwardAE = 2'd3;
    step("fwd_rsvd");
    check("fwd_rsvd.const", ALUOutM, 32'h25);

    // Immediate operand and RT destination; store data ignores ALUSrc.
    clear_inputs();
    ALUSrcE = 1; SignImmE = 32'hFFFF_FFFC; RD1E = 10; RD2E = 32'h55; ALUControlE = 3'd2;
    RegDstE = 0; RTE = 9; RDE = 4; MemWriteE = 1;
    step("imm");
    check("imm.const", ALUOutM, 32'd6);
    check("imm.wreg", 32'(WriteRegM), 32'd9);
    check("imm.wdata", WriteDataM, 32'h55);

    // Branch target with negative offset.
    clear_inputs();
    PCPlus4E = 32'h100; SignImmE = 32'hFFFF_FFFF; BranchE = 1;
    step("branch");
    check("branch.const", PCBranchM, 32'hFC);

    // Stall holds, flush beats stall, then normal loading resumes.
    clear_inputs();
    RD1E = 5; RD2E = 3; ALUControlE = 3'd2; RegWriteE = 1;
    step("pre_stall");
    RD1E = 100; RD2E = 200; StallM = 1; MemWriteE = 1;
    step("stall");
    check("stall.const", ALUOutM, 32'd8);
    FlushM = 1;
    step("flush");
    check("flush.valid", 32'(ValidM), 32'd0);
    StallM = 0; FlushM = 0;
    step("resume");
    check("resume.const", ALUOutM, 32'd300);

    // Randomized traffic, including stalls, flushes and reserved encodings.
    for (int unsigned i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
